compute_request_arbiter: RTL

- Sits directly upstream of the shared compute unit. Arbitrates up to NUM_UNITS requesting units (round-robin) and snapshots the winner's operands.
- Drives the shared unit's request/unit_id/operand inputs, waits for its done, then returns the result and a done pulse to the owning requester only.
- Adds a watchdog so a hung compute job cannot lock out other units.

---
 rtl/accel_pkg.sv | 29 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/compute_request_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator types: operand/result formats, operation codes and arbiter FSM states.
package accel_pkg;

  localparam int unsigned VECTOR_DEPTH = 4;
  localparam int unsigned VECTOR_WIDTH = 16;
  localparam int unsigned MATRIX_DEPTH = 4;

  typedef enum logic [1:0] {
    COMP_DOT,
    COMP_MATVEC,
    COMP_ADD,
    COMP_SCALE
  } computation_type_t;

  typedef logic [VECTOR_DEPTH-1:0][VECTOR_WIDTH-1:0] vector_data_t;

  // Ternary matrix cell: bit0 = nonzero, bit1 = sign.
  typedef logic [MATRIX_DEPTH-1:0][VECTOR_DEPTH-1:0][1:0] matrix_data_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid              = 1'b1;
        idx                = IDX_W'(cand);
        grant[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/compute_request_arbiter.sv
// Round-robin front end for the shared compute unit with operand snapshot and watchdog abort.
module compute_request_arbiter
  import accel_pkg::*;
#(
  parameter  int unsigned NUM_UNITS      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  localparam int unsigned ID_W           = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic              [NUM_UNITS-1:0]   req_i,
  input  computation_type_t [NUM_UNITS-1:0]   comp_type_i,
  input  vector_data_t      [NUM_UNITS-1:0]   vec_a_i,
  input  vector_data_t      [NUM_UNITS-1:0]   vec_b_i,
  input  matrix_data_t      [NUM_UNITS-1:0]   mat_i,
  output logic              [NUM_UNITS-1:0]   grant_o,
  output logic              [NUM_UNITS-1:0]   done_o,
  output vector_data_t                        result_o,
  output logic                                error_o,
  output logic                                cu_request_o,
  output logic              [ID_W-1:0]        cu_unit_id_o,
  output computation_type_t                   cu_comp_type_o,
  output vector_data_t                        cu_vector_a_o,
  output vector_data_t                        cu_vector_b_o,
  output matrix_data_t                        cu_matrix_o,
  input  logic                                cu_ready_i,
  input  logic                                cu_done_i,
  input  vector_data_t                        cu_result_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t                 state_q, state_d;
  logic       [ID_W-1:0]      rr_ptr_q;
  logic       [TW-1:0]        timer_q;
  logic                       abort_q;
  logic       [NUM_UNITS-1:0] pick_grant;
  logic       [ID_W-1:0]      pick_idx;
  logic                       pick_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_UNITS)
  ) u_picker (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cu_request_o = 1'b0;
    done_o       = '0;
    error_o      = 1'b0;
    case (state_q)
      ARB_IDLE:  if (pick_valid) state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        cu_request_o = cu_ready_i;
        if (cu_ready_i) state_d = ARB_WAIT;
      end
      ARB_WAIT:  if (cu_done_i || timer_q == T_LIMIT) state_d = ARB_RESP;
      ARB_RESP: begin
        done_o  = grant_o;
        error_o = abort_q;
        state_d = ARB_IDLE;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_o        <= '0;
      cu_unit_id_o   <= '0;
      cu_comp_type_o <= computation_type_t'('0);
      cu_vector_a_o  <= '0;
      cu_vector_b_o  <= '0;
      cu_matrix_o    <= '0;
      result_o       <= '0;
      rr_ptr_q       <= '0;
      timer_q        <= '0;
      abort_q        <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: if (pick_valid) begin
          grant_o        <= pick_grant;
          cu_unit_id_o   <= pick_idx;
          cu_comp_type_o <= comp_type_i[pick_idx];
          cu_vector_a_o  <= vec_a_i[pick_idx];
          cu_vector_b_o  <= vec_b_i[pick_idx];
          cu_matrix_o    <= mat_i[pick_idx];
          rr_ptr_q       <= (pick_idx == ID_W'(NUM_UNITS - 1)) ? '0 : pick_idx + 1'b1;
        end
        ARB_ISSUE: if (cu_ready_i) timer_q <= '0;
        // A done arriving on the expiry cycle takes priority over the abort.
        ARB_WAIT: begin
          if (cu_done_i) begin
            result_o <= cu_result_i;
          end else if (timer_q == T_LIMIT) begin
            result_o <= '0;
            abort_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ARB_RESP: begin
          grant_o <= '0;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
